// File: rtl/collision_scheduler_pkg.sv
// Shared types and box arithmetic for the T-rex collision sequencer.
// Boxes are relative {x,y,w,h}, 11-bit signed fields; positions are 12-bit signed.
package collision_scheduler_pkg;

  localparam int SLOT_W  = 2;
  localparam int CNT_W   = 3;
  localparam int POS_W   = 12;
  localparam int FIELD_W = 11;

  typedef struct packed {
    logic signed [FIELD_W-1:0] x;
    logic signed [FIELD_W-1:0] y;
    logic signed [FIELD_W-1:0] w;
    logic signed [FIELD_W-1:0] h;
  } collision_box_t;

  typedef struct packed {
    logic signed [POS_W-1:0] x;
    logic signed [POS_W-1:0] y;
    logic signed [POS_W-1:0] w;
    logic signed [POS_W-1:0] h;
  } adj_box_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_OBS,
    OUTER,
    FETCH_BOX,
    INNER,
    DONE
  } state_t;

  // Moves a relative box to absolute coordinates; the 12-bit add wraps.
  function automatic adj_box_t box_adjust(collision_box_t b,
                                          logic signed [POS_W-1:0] px,
                                          logic signed [POS_W-1:0] py);
    adj_box_t r;
    r.x = {b.x[FIELD_W-1], b.x} + px;
    r.y = {b.y[FIELD_W-1], b.y} + py;
    r.w = {b.w[FIELD_W-1], b.w};
    r.h = {b.h[FIELD_W-1], b.h};
    return r;
  endfunction

  // Strict overlap: boxes that only share an edge do not collide.
  function automatic logic box_compare(adj_box_t a, adj_box_t b);
    logic signed [POS_W-1:0] a_x2;
    logic signed [POS_W-1:0] a_y2;
    logic signed [POS_W-1:0] b_x2;
    logic signed [POS_W-1:0] b_y2;
    a_x2 = a.x + a.w;
    a_y2 = a.y + a.h;
    b_x2 = b.x + b.w;
    b_y2 = b.y + b.h;
    return (a.x < b_x2) && (a_x2 > b.x) && (a.y < b_y2) && (a_y2 > b.y);
  endfunction

endpackage

// File: rtl/collision_pair_check.sv
// Combinational box-pair test: places both boxes at their owners' positions
// and reports strict overlap. Shared between the outer and detail passes.
module collision_pair_check
  import collision_scheduler_pkg::*;
(
  input  logic [43:0]        i_box_a,
  input  logic signed [11:0] i_ax,
  input  logic signed [11:0] i_ay,
  input  logic [43:0]        i_box_b,
  input  logic signed [11:0] i_bx,
  input  logic signed [11:0] i_by,
  output logic               o_overlap
);

  adj_box_t w_a;
  adj_box_t w_b;

  always_comb begin
    w_a       = box_adjust(collision_box_t'(i_box_a), i_ax, i_ay);
    w_b       = box_adjust(collision_box_t'(i_box_b), i_bx, i_by);
    o_overlap = box_compare(w_a, w_b);
  end

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame collision sequencer: coarse outer-box scan over every obstacle slot,
// then a detail-pair walk through one shared comparator when the outer boxes meet.
module collision_scheduler
  import collision_scheduler_pkg::*;
#(
  parameter int MAX_OBSTACLES  = 3,
  parameter int MAX_TREX_BOXES = 6,
  parameter int MAX_OBS_BOXES  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [11:0] trex_x,
  input  logic signed [11:0] trex_y,
  input  logic [43:0]        trex_outer,
  input  logic [2:0]         trex_box_cnt,
  output logic [1:0]         obs_idx,
  input  logic               obs_valid,
  input  logic signed [11:0] obs_x,
  input  logic signed [11:0] obs_y,
  input  logic [43:0]        obs_outer,
  input  logic [2:0]         obs_box_cnt,
  output logic [2:0]         trex_box_addr,
  input  logic [43:0]        trex_box,
  output logic [2:0]         obs_box_addr,
  input  logic [43:0]        obs_box,
  output logic               busy,
  output logic               done,
  output logic               hit
);

  state_t r_state;
  state_t w_next;

  logic [SLOT_W-1:0]       r_obs_idx;
  logic [CNT_W-1:0]        r_j;
  logic [CNT_W-1:0]        r_k;
  logic                    r_hit;

  logic signed [11:0]      r_trex_x;
  logic signed [11:0]      r_trex_y;
  logic [43:0]             r_trex_outer;
  logic [CNT_W-1:0]        r_trex_cnt;
  logic signed [11:0]      r_obs_x;
  logic signed [11:0]      r_obs_y;
  logic [CNT_W-1:0]        r_obs_cnt;

  logic                    w_inner;
  logic [43:0]             w_box_a;
  logic [43:0]             w_box_b;
  logic signed [11:0]      w_bx;
  logic signed [11:0]      w_by;
  logic                    w_overlap;
  logic                    w_outer_go;
  logic                    w_last_slot;
  logic [CNT_W-1:0]        w_j_inc;
  logic [CNT_W-1:0]        w_k_inc;
  logic                    w_k_wrap;
  logic                    w_last_pair;
  logic [CNT_W-1:0]        w_trex_cnt_clamp;
  logic [CNT_W-1:0]        w_obs_cnt_clamp;

  // Counts beyond the ROM depth would address boxes that do not exist.
  assign w_trex_cnt_clamp = (trex_box_cnt > CNT_W'(MAX_TREX_BOXES)) ?
                            CNT_W'(MAX_TREX_BOXES) : trex_box_cnt;
  assign w_obs_cnt_clamp  = (obs_box_cnt > CNT_W'(MAX_OBS_BOXES)) ?
                            CNT_W'(MAX_OBS_BOXES) : obs_box_cnt;

  assign w_inner = (r_state == INNER);
  assign w_box_a = w_inner ? trex_box : r_trex_outer;
  assign w_box_b = w_inner ? obs_box  : obs_outer;
  assign w_bx    = w_inner ? r_obs_x  : obs_x;
  assign w_by    = w_inner ? r_obs_y  : obs_y;

  collision_pair_check u_pair_check (
    .i_box_a   (w_box_a),
    .i_ax      (r_trex_x),
    .i_ay      (r_trex_y),
    .i_box_b   (w_box_b),
    .i_bx      (w_bx),
    .i_by      (w_by),
    .o_overlap (w_overlap)
  );

  assign w_outer_go  = obs_valid && w_overlap && (r_trex_cnt != '0) && (obs_box_cnt != '0);
  assign w_last_slot = (r_obs_idx == SLOT_W'(MAX_OBSTACLES - 1));
  assign w_j_inc     = r_j + CNT_W'(1);
  assign w_k_inc     = r_k + CNT_W'(1);
  assign w_k_wrap    = (w_k_inc == r_obs_cnt);
  assign w_last_pair = w_k_wrap && (w_j_inc == r_trex_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_obs_idx <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_hit     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_hit     <= 1'b0;
            r_obs_idx <= '0;
          end
        end
        OUTER: begin
          if (w_outer_go) begin
            r_j <= '0;
            r_k <= '0;
          end else if (!w_last_slot) begin
            r_obs_idx <= r_obs_idx + SLOT_W'(1);
          end
        end
        INNER: begin
          if (w_overlap) begin
            r_hit <= 1'b1;
          end else if (w_k_wrap) begin
            r_k <= '0;
            r_j <= w_j_inc;
            if (w_last_pair && !w_last_slot) begin
              r_obs_idx <= r_obs_idx + SLOT_W'(1);
            end
          end else begin
            r_k <= w_k_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand latches carry no reset: they are always written before use.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && start) begin
      r_trex_x     <= trex_x;
      r_trex_y     <= trex_y;
      r_trex_outer <= trex_outer;
      r_trex_cnt   <= w_trex_cnt_clamp;
    end
    if (r_state == OUTER && w_outer_go) begin
      r_obs_x   <= obs_x;
      r_obs_y   <= obs_y;
      r_obs_cnt <= w_obs_cnt_clamp;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (start) w_next = FETCH_OBS;
      FETCH_OBS: w_next = OUTER;
      OUTER: begin
        if (w_outer_go)       w_next = FETCH_BOX;
        else if (w_last_slot) w_next = DONE;
        else                  w_next = FETCH_OBS;
      end
      FETCH_BOX: w_next = INNER;
      INNER: begin
        if (w_overlap)        w_next = DONE;
        else if (!w_last_pair) w_next = FETCH_BOX;
        else if (w_last_slot) w_next = DONE;
        else                  w_next = FETCH_OBS;
      end
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    busy          = (r_state != IDLE) && (r_state != DONE);
    done          = (r_state == DONE);
    hit           = r_hit;
    obs_idx       = r_obs_idx;
    trex_box_addr = r_j;
    obs_box_addr  = r_k;
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Bench for collision_scheduler: directed scenarios plus random scenes, each
// checked against a slot/pair walk computed with plain integer arithmetic.
module tb_collision_scheduler;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic signed [11:0] trex_x = '0;
  logic signed [11:0] trex_y = '0;
  logic [43:0]        trex_outer = '0;
  logic [2:0]         trex_box_cnt = '0;
  logic [1:0]         obs_idx;
  logic               obs_valid = 1'b0;
  logic signed [11:0] obs_x = '0;
  logic signed [11:0] obs_y = '0;
  logic [43:0]        obs_outer = '0;
  logic [2:0]         obs_box_cnt = '0;
  logic [2:0]         trex_box_addr;
  logic [43:0]        trex_box = '0;
  logic [2:0]         obs_box_addr;
  logic [43:0]        obs_box = '0;
  logic               busy, done, hit;

  int n_cmp = 0;
  int n_err = 0;

  // Scene description
  int tx, ty, tc;
  int to[4];
  int tbx[8][4];
  bit sv[4];
  int sx[4], sy[4], sc[4];
  int so[4][4];
  int obx[4][8][4];

  collision_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .trex_x(trex_x), .trex_y(trex_y), .trex_outer(trex_outer), .trex_box_cnt(trex_box_cnt),
    .obs_idx(obs_idx), .obs_valid(obs_valid), .obs_x(obs_x), .obs_y(obs_y),
    .obs_outer(obs_outer), .obs_box_cnt(obs_box_cnt),
    .trex_box_addr(trex_box_addr), .trex_box(trex_box),
    .obs_box_addr(obs_box_addr), .obs_box(obs_box),
    .busy(busy), .done(done), .hit(hit)
  );

  always #5 clk = ~clk;

  function automatic logic [43:0] mk(int x, int y, int w, int h);
    return {x[10:0], y[10:0], w[10:0], h[10:0]};
  endfunction

  // Registered ROM / obstacle table: data follows the address by one cycle.
  always @(posedge clk) begin
    obs_valid   <= sv[obs_idx];
    obs_x       <= 12'(sx[obs_idx]);
    obs_y       <= 12'(sy[obs_idx]);
    obs_outer   <= mk(so[obs_idx][0], so[obs_idx][1], so[obs_idx][2], so[obs_idx][3]);
    obs_box_cnt <= 3'(sc[obs_idx]);
    trex_box    <= mk(tbx[trex_box_addr][0], tbx[trex_box_addr][1],
                      tbx[trex_box_addr][2], tbx[trex_box_addr][3]);
    obs_box     <= mk(obx[obs_idx][obs_box_addr][0], obx[obs_idx][obs_box_addr][1],
                      obx[obs_idx][obs_box_addr][2], obx[obs_idx][obs_box_addr][3]);
  end

  function automatic int w12(int v);
    logic [11:0] t;
    t = v[11:0];
    return int'($signed(t));
  endfunction

  // Absolute-coordinate overlap of two placed rectangles, edges exclusive.
  function automatic bit rect_hit(int ax, int ay, int aw, int ah, int bx, int by, int bw, int bh);
    return (ax < w12(bx + bw)) && (w12(ax + aw) > bx) && (ay < w12(by + bh)) && (w12(ay + ah) > by);
  endfunction

  // Reference: result and cycle (start = cycle 0) at which done is seen.
  function automatic void model(output bit eh, output int ecyc);
    eh = 0;
    ecyc = 1;
    for (int s = 0; s < 3; s++) begin
      ecyc += 2;
      if (sv[s] && tc != 0 && sc[s] != 0 &&
          rect_hit(w12(tx + to[0]), w12(ty + to[1]), to[2], to[3],
                   w12(sx[s] + so[s][0]), w12(sy[s] + so[s][1]), so[s][2], so[s][3])) begin
        for (int j = 0; j < tc; j++) begin
          for (int k = 0; k < sc[s]; k++) begin
            ecyc += 2;
            if (rect_hit(w12(tx + tbx[j][0]), w12(ty + tbx[j][1]), tbx[j][2], tbx[j][3],
                         w12(sx[s] + obx[s][k][0]), w12(sy[s] + obx[s][k][1]),
                         obx[s][k][2], obx[s][k][3])) begin
              eh = 1;
              return;
            end
          end
        end
      end
    end
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0d expected=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic clear_scene();
    for (int s = 0; s < 4; s++) begin
      sv[s] = 0; sx[s] = 0; sy[s] = 0; sc[s] = 0;
      for (int f = 0; f < 4; f++) so[s][f] = 0;
      for (int b = 0; b < 8; b++) for (int f = 0; f < 4; f++) obx[s][b][f] = 0;
    end
    for (int b = 0; b < 8; b++) for (int f = 0; f < 4; f++) tbx[b][f] = 0;
  endtask

  task automatic base_trex();
    tx = 50; ty = 100; tc = 2;
    to[0] = 0; to[1] = 0; to[2] = 44; to[3] = 47;
    tbx[0][0] = 22; tbx[0][1] = 0;  tbx[0][2] = 17; tbx[0][3] = 16;
    tbx[1][0] = 1;  tbx[1][1] = 18; tbx[1][2] = 30; tbx[1][3] = 9;
  endtask

  task automatic set_slot(int s, int x, int y, int c);
    sv[s] = 1; sx[s] = x; sy[s] = y; sc[s] = c;
    so[s][0] = 0; so[s][1] = 0; so[s][2] = 17; so[s][3] = 35;
  endtask

  // Starts a check and follows it to done; fixed_cyc < 0 means no constant target.
  task automatic run_check(string tag, bit poke_start, int fixed_cyc);
    bit eh;
    int ec, n, got;
    model(eh, ec);
    trex_x = 12'(tx); trex_y = 12'(ty);
    trex_outer = mk(to[0], to[1], to[2], to[3]);
    trex_box_cnt = 3'(tc);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 1; got = -1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_hitclr"}, 32'(hit), 32'd0);
    while (n < 400) begin
      if (done) begin got = n; break; end
      start = (poke_start && (n == 3 || n == 4)) ? 1'b1 : 1'b0;
      @(posedge clk); #1 n++;
    end
    start = 1'b0;
    chk({tag, "_cyc"}, 32'(got), 32'(ec));
    if (fixed_cyc >= 0) chk({tag, "_cyc_abs"}, 32'(got), 32'(fixed_cyc));
    chk({tag, "_hit"}, 32'(hit), 32'(eh));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hit_hold"}, 32'(hit), 32'(eh));
  endtask

  initial begin
    clear_scene();
    base_trex();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_idx", 32'(obs_idx), 32'd0);
    chk("rst_taddr", 32'(trex_box_addr), 32'd0);
    chk("rst_oaddr", 32'(obs_box_addr), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("idle_busy", 32'(busy), 32'd0);

    // No overlap
    clear_scene(); base_trex();
    set_slot(0, 200, 105, 1);
    obx[0][0][2] = 5; obx[0][0][3] = 35;
    run_check("nolap", 0, 7);

    // Edge touch, then one pixel in (outer entered, details miss)
    set_slot(0, 94, 105, 1);
    run_check("touch", 0, 7);
    set_slot(0, 93, 105, 1);
    obx[0][0][0] = 10;
    run_check("justin", 0, 11);

    // Detail hit on the first pair
    clear_scene(); base_trex();
    set_slot(0, 80, 105, 1);
    obx[0][0][2] = 5; obx[0][0][3] = 35;
    set_slot(1, 80, 105, 1);
    obx[1][0][2] = 5; obx[1][0][3] = 35;
    run_check("dhit", 0, 5);

    // Outer overlap on slot 1, all details miss
    clear_scene(); base_trex();
    set_slot(1, 93, 105, 2);
    obx[1][0][0] = 5;  obx[1][0][2] = 5; obx[1][0][3] = 10;
    obx[1][1][0] = 10; obx[1][1][1] = 20; obx[1][1][2] = 5; obx[1][1][3] = 10;
    run_check("allmiss", 0, 15);

    // Start pulses while busy do not disturb the run
    run_check("busystart", 1, 15);

    // Outer overlap but zero detail boxes
    sc[1] = 0;
    run_check("zerocnt", 0, 7);
    sc[1] = 2;

    // Reset mid-INNER aborts without done
    trex_box_cnt = 3'(tc);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_idx", 32'(obs_idx), 32'd0);
    chk("rstmid_addr", 32'({trex_box_addr, obs_box_addr}), 32'd0);
    rst_n = 1'b1;
    begin
      int dones = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (done) dones++;
      end
      chk("rstmid_nodone", 32'(dones), 32'd0);
    end

    // Negative T-rex position
    clear_scene(); base_trex();
    tx = -20;
    set_slot(2, 10, 105, 1);
    obx[2][0][2] = 5; obx[2][0][3] = 35;
    run_check("negx", 0, 9);

    // Random scenes, including positions near the 12-bit wrap
    for (int it = 0; it < 25; it++) begin
      clear_scene();
      tx = int'($urandom_range(0, 3) == 0 ? $urandom_range(1990, 2100) : $urandom_range(0, 200)) - 40;
      ty = int'($urandom_range(0, 120));
      tc = int'($urandom_range(0, 6));
      to[0] = 0; to[1] = 0; to[2] = int'($urandom_range(10, 60)); to[3] = int'($urandom_range(10, 60));
      for (int b = 0; b < 6; b++) begin
        tbx[b][0] = int'($urandom_range(0, 40)); tbx[b][1] = int'($urandom_range(0, 40));
        tbx[b][2] = int'($urandom_range(1, 20)); tbx[b][3] = int'($urandom_range(1, 20));
      end
      for (int s = 0; s < 3; s++) begin
        sv[s] = ($urandom_range(0, 3) != 0);
        sx[s] = tx + int'($urandom_range(0, 100)) - 40;
        sy[s] = ty + int'($urandom_range(0, 80)) - 40;
        sc[s] = int'($urandom_range(0, 5));
        so[s][0] = 0; so[s][1] = 0;
        so[s][2] = int'($urandom_range(5, 40)); so[s][3] = int'($urandom_range(5, 40));
        for (int b = 0; b < 5; b++) begin
          obx[s][b][0] = int'($urandom_range(0, 30)); obx[s][b][1] = int'($urandom_range(0, 30));
          obx[s][b][2] = int'($urandom_range(1, 12)); obx[s][b][3] = int'($urandom_range(1, 12));
        end
      end
      run_check($sformatf("rnd%0d", it), ($urandom_range(0, 3) == 0), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
